// File: rtl/imem_prog_loader.sv
// Framed byte-stream loader for instruction memory.
// Holds the CPU in reset while loading; releases it on a good checksum.
module imem_prog_loader #(
    parameter int unsigned        ADDR_W    = 8,
    parameter logic [7:0]         SYNC_BYTE = 8'hA5,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [8:0]        byte_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            r_state, w_state_nx;
    logic [8:0]        r_remain, w_remain_nx;
    logic [7:0]        r_sum, w_sum_nx;
    logic              r_we, w_we_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic [7:0]        r_wdata, w_wdata_nx;
    logic              r_hold, w_hold_nx;
    logic              r_done, w_done_nx;
    logic              r_err, w_err_nx;
    logic [8:0]        r_cnt, w_cnt_nx;
    logic              w_ready;
    logic              w_acc;

    // Ready depends only on the registered state
    assign w_ready = (r_state == S_SYNC) || (r_state == S_LEN) ||
                     (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_acc   = in_valid && w_ready;

    always_comb begin
        w_state_nx  = r_state;
        w_remain_nx = r_remain;
        w_sum_nx    = r_sum;
        w_we_nx     = 1'b0;
        w_addr_nx   = r_addr;
        w_wdata_nx  = r_wdata;
        w_hold_nx   = r_hold;
        w_done_nx   = r_done;
        w_err_nx    = r_err;
        w_cnt_nx    = r_cnt;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_nx = S_SYNC;
                    w_hold_nx  = 1'b1;
                    w_done_nx  = 1'b0;
                    w_err_nx   = 1'b0;
                    w_cnt_nx   = '0;
                    w_sum_nx   = '0;
                end
            end
            S_SYNC: begin
                if (w_acc && in_data == SYNC_BYTE)
                    w_state_nx = S_LEN;
            end
            S_LEN: begin
                if (w_acc) begin
                    w_remain_nx = (in_data == 8'd0) ? 9'd256
                                                    : {1'b0, in_data};
                    w_state_nx  = S_DATA;
                end
            end
            S_DATA: begin
                if (w_acc) begin
                    w_we_nx     = 1'b1;
                    w_wdata_nx  = in_data;
                    w_addr_nx   = BASE_ADDR + ADDR_W'(r_cnt);
                    w_cnt_nx    = r_cnt + 9'd1;
                    w_remain_nx = r_remain - 9'd1;
                    w_sum_nx    = r_sum + in_data;
                    if (r_remain == 9'd1)
                        w_state_nx = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_acc) begin
                    if (in_data == r_sum) begin
                        w_state_nx = S_DONE;
                        w_done_nx  = 1'b1;
                        w_hold_nx  = 1'b0;
                    end else begin
                        w_state_nx = S_ERR;
                        w_err_nx   = 1'b1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_remain <= '0;
            r_sum    <= '0;
            r_we     <= 1'b0;
            r_addr   <= BASE_ADDR;
            r_wdata  <= '0;
            r_hold   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_remain <= w_remain_nx;
            r_sum    <= w_sum_nx;
            r_we     <= w_we_nx;
            r_addr   <= w_addr_nx;
            r_wdata  <= w_wdata_nx;
            r_hold   <= w_hold_nx;
            r_done   <= w_done_nx;
            r_err    <= w_err_nx;
            r_cnt    <= w_cnt_nx;
        end
    end

    assign in_ready   = w_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = r_hold;
    assign done       = r_done;
    assign err        = r_err;
    assign byte_count = r_cnt;

endmodule
